// File: rtl/spi_responder_if.sv
// Bus bundle between the SPI responder and its master/monitor.
//   mosi        master -> responder serial data
//   miso        responder -> master serial data
//   tx_data/tx_valid/tx_ready   user push into the response FIFO
//   rx_data/rx_valid/rx_ready   user pop from the capture FIFO
//   tx_underrun                 one-cycle pulse, idle byte loaded
//   rx_overflow                 sticky, a captured byte was dropped
interface spi_responder_if;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       tx_underrun;
  logic       rx_overflow;

  // Responder side
  modport slave (
    input  mosi, tx_data, tx_valid, rx_ready,
    output miso, tx_ready, rx_data, rx_valid, tx_underrun, rx_overflow
  );

  // Master / user side
  modport master (
    output mosi, tx_data, tx_valid, rx_ready,
    input  miso, tx_ready, rx_data, rx_valid, tx_underrun, rx_overflow
  );
endinterface

// File: rtl/spi_responder.sv
// SPI responder: free-running 8-bit MSB-first frames clocked by sck, no
// chip select. Captured mosi bytes go to an RX FIFO; response bytes are
// taken from a TX FIFO at each frame load, or IDLE_BYTE when it is empty.
// Ports:
//   sck  bus clock, all logic on posedge
//   rst  asynchronous active-high reset
//   bus  spi_responder_if.slave (serial lines plus TX/RX FIFO handshakes)
module spi_responder #(
  parameter int unsigned TX_DEPTH  = 4,
  parameter int unsigned RX_DEPTH  = 4,
  parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
  input  logic           sck,
  input  logic           rst,
  spi_responder_if.slave bus
);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_PW = TX_AW + 1;
  localparam int unsigned RX_PW = RX_AW + 1;

  logic [2:0]       bit_cnt;
  logic [7:0]       rx_shift;
  logic [7:0]       tx_shift;
  logic             tx_ready_q;
  logic             rx_valid_q;
  logic             tx_underrun_q;
  logic             rx_overflow_q;

  logic [7:0]       tx_mem [TX_DEPTH];
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [TX_PW-1:0] tx_wr_ptr, tx_rd_ptr, tx_wr_nxt, tx_rd_nxt;
  logic [RX_PW-1:0] rx_wr_ptr, rx_rd_ptr, rx_wr_nxt, rx_rd_nxt;

  logic             frame_end_c;
  logic             tx_empty_c;
  logic             tx_push_c;
  logic             tx_pop_c;
  logic             rx_full_c;
  logic             rx_pop_c;
  logic             rx_push_c;
  logic             rx_drop_c;
  logic [7:0]       rx_byte_c;

  // Frame timing and FIFO pointer arithmetic
  always_comb begin
    frame_end_c = (bit_cnt == 3'd7);
    tx_empty_c  = (tx_wr_ptr == tx_rd_ptr);
    tx_push_c   = bus.tx_valid && tx_ready_q;
    tx_pop_c    = frame_end_c && !tx_empty_c;
    rx_full_c   = ((rx_wr_ptr - rx_rd_ptr) == RX_PW'(RX_DEPTH));
    rx_pop_c    = bus.rx_ready && rx_valid_q;
    // A pop on the same edge frees the slot the push lands in
    rx_push_c   = frame_end_c && (!rx_full_c || rx_pop_c);
    rx_drop_c   = frame_end_c && rx_full_c && !rx_pop_c;
    rx_byte_c   = {rx_shift[6:0], bus.mosi};
    tx_wr_nxt   = tx_wr_ptr + TX_PW'(tx_push_c);
    tx_rd_nxt   = tx_rd_ptr + TX_PW'(tx_pop_c);
    rx_wr_nxt   = rx_wr_ptr + RX_PW'(rx_push_c);
    rx_rd_nxt   = rx_rd_ptr + RX_PW'(rx_pop_c);
  end

  // Shift registers, pointers and status flags
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      bit_cnt       <= 3'd0;
      rx_shift      <= 8'h00;
      tx_shift      <= IDLE_BYTE;
      tx_wr_ptr     <= '0;
      tx_rd_ptr     <= '0;
      rx_wr_ptr     <= '0;
      rx_rd_ptr     <= '0;
      tx_ready_q    <= 1'b1;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      rx_overflow_q <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt + 3'd1;
      rx_shift  <= rx_byte_c;
      tx_wr_ptr <= tx_wr_nxt;
      tx_rd_ptr <= tx_rd_nxt;
      rx_wr_ptr <= rx_wr_nxt;
      rx_rd_ptr <= rx_rd_nxt;
      // Flags follow the post-edge occupancy so they are plain flops
      tx_ready_q    <= ((tx_wr_nxt - tx_rd_nxt) != TX_PW'(TX_DEPTH));
      rx_valid_q    <= (rx_wr_nxt != rx_rd_nxt);
      tx_underrun_q <= frame_end_c && tx_empty_c;
      if (rx_drop_c) begin
        rx_overflow_q <= 1'b1;
      end
      if (frame_end_c) begin
        // Empty check uses pre-edge pointers: a same-edge push waits a frame
        tx_shift <= tx_empty_c ? IDLE_BYTE : tx_mem[tx_rd_ptr[TX_AW-1:0]];
      end else begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  // FIFO storage, data only, no reset needed
  always_ff @(posedge sck) begin
    if (tx_push_c) begin
      tx_mem[tx_wr_ptr[TX_AW-1:0]] <= bus.tx_data;
    end
    if (rx_push_c) begin
      rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_byte_c;
    end
  end

  assign bus.miso        = tx_shift[7];
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_data     = rx_mem[rx_rd_ptr[RX_AW-1:0]];
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.rx_overflow = rx_overflow_q;
endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: a queue-based frame model checks
// every output after every edge, and directed tables/sequences check the
// serialised bytes, pulses and FIFO ordering against fixed expectations.
module tb_spi_responder;
  localparam int unsigned TX_DEPTH  = 4;
  localparam int unsigned RX_DEPTH  = 4;
  localparam logic [7:0]  IDLE_BYTE = 8'hFF;

  logic sck;
  logic rst;
  spi_responder_if bus ();

  spi_responder #(
    .TX_DEPTH (TX_DEPTH),
    .RX_DEPTH (RX_DEPTH),
    .IDLE_BYTE(IDLE_BYTE)
  ) dut (
    .sck(sck),
    .rst(rst),
    .bus(bus)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  int total = 0;
  int bad   = 0;

  // Frame-level reference model
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  pop_log[$];
  int unsigned m_n;
  logic [7:0]  m_cur;
  logic [7:0]  m_acc;
  logic        m_und;
  logic        m_ovf;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    m_n   = 0;
    m_cur = IDLE_BYTE;
    m_und = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input logic m, input logic tv, input logic [7:0] td, input logic rr);
    bit tx_rdy_pre;
    bit pop;
    tx_rdy_pre = (tx_q.size() < TX_DEPTH);
    pop        = (rx_q.size() != 0) && rr;
    m_acc      = {m_acc[6:0], m};
    m_und      = 1'b0;
    if (pop) void'(rx_q.pop_front());
    if (m_n % 8 == 7) begin
      if (rx_q.size() < RX_DEPTH) rx_q.push_back(m_acc);
      else m_ovf = 1'b1;
      if (tx_q.size() != 0) m_cur = tx_q.pop_front();
      else begin
        m_cur = IDLE_BYTE;
        m_und = 1'b1;
      end
    end
    if (tv && tx_rdy_pre) tx_q.push_back(td);
    m_n++;
  endtask

  task automatic check_all(input string tag);
    int idx;
    idx = 7 - int'(m_n % 8);
    chk({tag, ".miso"},        8'(bus.miso),        8'(m_cur[idx]));
    chk({tag, ".tx_ready"},    8'(bus.tx_ready),    8'(tx_q.size() < TX_DEPTH));
    chk({tag, ".rx_valid"},    8'(bus.rx_valid),    8'(rx_q.size() != 0));
    chk({tag, ".tx_underrun"}, 8'(bus.tx_underrun), 8'(m_und));
    chk({tag, ".rx_overflow"}, 8'(bus.rx_overflow), 8'(m_ovf));
    if (rx_q.size() != 0) chk({tag, ".rx_data"}, bus.rx_data, rx_q[0]);
  endtask

  // One sck cycle; smiso is the bit the master samples at this edge
  task automatic cycle(input logic m, input logic tv, input logic [7:0] td, input logic rr,
                       output logic smiso);
    bus.mosi     = m;
    bus.tx_valid = tv;
    bus.tx_data  = td;
    bus.rx_ready = rr;
    smiso = bus.miso;
    if (bus.rx_valid && rr) pop_log.push_back(bus.rx_data);
    model_step(m, tv, td, rr);
    @(posedge sck);
    #1;
    check_all("model");
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
  endtask

  task automatic frame(input logic [7:0] mb, input logic [7:0] pmask, input logic [63:0] pb,
                       input logic [7:0] rmask, output logic [7:0] mb_out, output logic und_end);
    logic s;
    mb_out = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cycle(mb[7-i], pmask[i], pb[i*8 +: 8], rmask[i], s);
      mb_out = {mb_out[6:0], s};
    end
    und_end = bus.tx_underrun;
  endtask

  task automatic drain(input int k);
    logic s;
    for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1, s);
  endtask

  task automatic chk_log(input string name, input logic [63:0] exp_bytes, input int n);
    chk({name, ".count"}, 8'(pop_log.size()), 8'(n));
    for (int i = 0; i < n && i < pop_log.size(); i++)
      chk($sformatf("%s.byte%0d", name, i), pop_log[i], exp_bytes[i*8 +: 8]);
    pop_log.delete();
  endtask

  // Called at #1 after an edge; release lands just before the next frame edge
  task automatic do_reset();
    rst          = 1'b1;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    bus.mosi     = 1'b0;
    model_reset();
    #1;
    check_all("reset_async");
    repeat (2) @(posedge sck);
    #1;
    check_all("reset_hold");
    rst = 1'b0;
    pop_log.delete();
  endtask

  typedef struct {
    logic [7:0]  mosi;
    logic [7:0]  pmask;
    logic [63:0] pbytes;
    logic [7:0]  rmask;
    logic [7:0]  exp_miso;
    logic        exp_und;
  } fvec_t;

  initial begin
    fvec_t       t2[4];
    logic [7:0]  mb;
    logic        und;
    logic        s;
    logic [7:0]  sent_tx[$];
    logic [7:0]  sent_rx[$];

    t2[0] = '{8'h5A, 8'h03, 64'h3CA5, 8'h00, 8'hFF, 1'b0};
    t2[1] = '{8'hC3, 8'h00, 64'h0,    8'h00, 8'hA5, 1'b0};
    t2[2] = '{8'h00, 8'h00, 64'h0,    8'h00, 8'h3C, 1'b1};
    t2[3] = '{8'h96, 8'h01, 64'h77,   8'h00, 8'hFF, 1'b0};

    rst = 1'b1;
    bus.mosi = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = 8'h00; bus.rx_ready = 1'b0;
    m_acc = 8'h00;
    @(posedge sck);
    #1;
    do_reset();

    // Some traffic, then a reset in the middle of it
    for (int i = 0; i < 30; i++)
      cycle(1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), s);
    do_reset();

    // Basic framing, push latency and underrun pulse
    foreach (t2[i]) begin
      frame(t2[i].mosi, t2[i].pmask, t2[i].pbytes, t2[i].rmask, mb, und);
      chk($sformatf("t2.frame%0d.miso", i), mb, t2[i].exp_miso);
      chk($sformatf("t2.frame%0d.und", i), 8'(und), 8'(t2[i].exp_und));
    end
    drain(4);
    chk_log("t2.rx", 64'h9600C35A, 4);

    // RX overflow: six frames with no pops
    do_reset();
    for (int f = 0; f < 6; f++) begin
      frame(8'(8'h11 * (f + 1)), 8'h00, 64'h0, 8'h00, mb, und);
      if (f == 3) chk("t3.ovf_after_full", 8'(bus.rx_overflow), 8'h00);
    end
    chk("t3.ovf_set", 8'(bus.rx_overflow), 8'h01);
    drain(4);
    chk_log("t3.rx", 64'h44332211, 4);

    // TX full ignores a push; RX full with pop at frame end keeps the byte
    do_reset();
    cycle(1'b0, 1'b1, 8'h11, 1'b0, s);
    cycle(1'b0, 1'b1, 8'h22, 1'b0, s);
    cycle(1'b0, 1'b1, 8'h33, 1'b0, s);
    cycle(1'b0, 1'b1, 8'h44, 1'b0, s);
    chk("t4.tx_full", 8'(bus.tx_ready), 8'h00);
    cycle(1'b0, 1'b1, 8'h55, 1'b0, s);
    chk("t4.tx_still_full", 8'(bus.tx_ready), 8'h00);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, s);
    frame(8'hB1, 8'h00, 64'h0, 8'h00, mb, und);
    chk("t4.miso1", mb, 8'h11);
    frame(8'hB2, 8'h00, 64'h0, 8'h00, mb, und);
    chk("t4.miso2", mb, 8'h22);
    frame(8'hB3, 8'h00, 64'h0, 8'h00, mb, und);
    chk("t4.miso3", mb, 8'h33);
    frame(8'hB4, 8'h00, 64'h0, 8'h80, mb, und);
    chk("t4.miso4", mb, 8'h44);
    chk("t4.und4", 8'(und), 8'h01);
    chk("t4.no_ovf", 8'(bus.rx_overflow), 8'h00);
    frame(8'h5F, 8'h00, 64'h0, 8'h0F, mb, und);
    chk("t4.miso5_idle", mb, IDLE_BYTE);
    chk_log("t4.rx", 64'hB4B3B2B100, 5);

    // Reset at bit_cnt=3 with two TX bytes queued
    do_reset();
    cycle(1'b1, 1'b1, 8'hAA, 1'b0, s);
    cycle(1'b0, 1'b1, 8'hBB, 1'b0, s);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, s);
    do_reset();
    frame(8'h3C, 8'h00, 64'h0, 8'h00, mb, und);
    chk("t5.miso_idle", mb, IDLE_BYTE);
    chk("t5.und_flushed", 8'(und), 8'h01);
    drain(1);
    chk_log("t5.rx", 64'h3C, 1);
    chk("t5.rx_empty", 8'(bus.rx_valid), 8'h00);

    // Streaming across pointer wrap
    do_reset();
    for (int f = 0; f < 21; f++) begin
      logic [7:0] b;
      logic [7:0] m;
      b = 8'($urandom);
      m = 8'($urandom);
      sent_rx.push_back(m);
      if (f < 20) sent_tx.push_back(b);
      frame(m, (f < 20) ? 8'h01 : 8'h00, 64'(b), 8'hFF, mb, und);
      chk($sformatf("t6.miso%0d", f), mb, (f == 0) ? IDLE_BYTE : sent_tx[f-1]);
      if (f < 20) chk($sformatf("t6.und%0d", f), 8'(und), 8'h00);
    end
    drain(1);
    chk("t6.rx_count", 8'(pop_log.size()), 8'(sent_rx.size()));
    for (int i = 0; i < sent_rx.size() && i < pop_log.size(); i++)
      chk($sformatf("t6.rx%0d", i), pop_log[i], sent_rx[i]);
    chk("t6.no_ovf", 8'(bus.rx_overflow), 8'h00);
    pop_log.delete();

    // Random traffic against the model
    for (int i = 0; i < 1500; i++)
      cycle(1'($urandom), ($urandom_range(2) != 0), 8'($urandom), 1'($urandom), s);
    do_reset();
    for (int i = 0; i < 500; i++)
      cycle(1'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(3) == 0), s);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end
endmodule
